img_window_reader: RTL and testbench

IMG_WINDOW_READER -- requirements
Module: img_window_reader

---
 rtl/img_conv_pkg.sv | 40 ++++
 rtl/img_tap_bounds.sv | 44 ++++
 rtl/img_window_reader.sv | 235 +++++++++++++++++++++++
 tb/tb_img_window_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_conv_pkg.sv
// img_conv_pkg
// Shared definitions for the image window reader:
//   - state_t      : reader FSM states (also exported on the debug port)
//   - MAX_DIM      : largest supported image dimension (SRAM is MAX_DIM x MAX_DIM)
//   - NUM_TAPS     : taps in a 3x3 window
//   - TAP_DR/TAP_DC: row/column offset of tap k relative to the window centre
//   - shift_tap_idx: tap refetched in the n-th slot when the window slides right
package img_conv_pkg;

  localparam int MAX_DIM  = 256;
  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Tap k sits at (dr, dc) = (k/3 - 1, k%3 - 1); k=0 is top-left, k=4 is the centre.
  localparam logic signed [1:0] TAP_DR [NUM_TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };
  localparam logic signed [1:0] TAP_DC [NUM_TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };

  // After a one-column slide only the right-hand column (k = 2, 5, 8) is new.
  function automatic logic [3:0] shift_tap_idx(input logic [3:0] slot);
    case (slot)
      4'd0:    return 4'd2;
      4'd1:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/img_tap_bounds.sv
// img_tap_bounds
// Combinational address generator for one window tap.
//   tap_idx    : tap index k (0..8)
//   centre_row : window centre row
//   centre_col : window centre column
//   addr_row   : SRAM row of the tap (meaningful only when in_bounds)
//   addr_col   : SRAM column of the tap (meaningful only when in_bounds)
//   in_bounds  : tap lies inside the IMG_ROWS x IMG_COLS image; when low the
//                caller must not strobe the SRAM and must load 0x00 instead.
module img_tap_bounds
  import img_conv_pkg::*;
#(
  parameter int IMG_ROWS = 256,
  parameter int IMG_COLS = 256
) (
  input  logic [3:0] tap_idx,
  input  logic [7:0] centre_row,
  input  logic [7:0] centre_col,
  output logic [7:0] addr_row,
  output logic [7:0] addr_col,
  output logic       in_bounds
);

  logic signed [1:0] dr;
  logic signed [1:0] dc;
  logic signed [8:0] row_s;
  logic signed [8:0] col_s;

  // Offsets are added in 9-bit signed arithmetic. 0-1 becomes -1 and 255+1
  // becomes 9'h100, whose sign bit is set, so both land in the "negative"
  // branch and are rejected instead of wrapping onto a real pixel.
  always_comb begin
    dr        = TAP_DR[tap_idx];
    dc        = TAP_DC[tap_idx];
    row_s     = $signed({1'b0, centre_row}) + $signed({{7{dr[1]}}, dr});
    col_s     = $signed({1'b0, centre_col}) + $signed({{7{dc[1]}}, dc});
    addr_row  = row_s[7:0];
    addr_col  = col_s[7:0];
    in_bounds = !row_s[8] && !col_s[8]
             && ($unsigned(row_s) < 9'(IMG_ROWS))
             && ($unsigned(col_s) < 9'(IMG_COLS));
  end

endmodule

// File: rtl/img_window_reader.sv
// img_window_reader
// Scans an IMG_ROWS x IMG_COLS image held in a 256x256 byte SRAM and emits
// one 3x3 window per pixel, in raster order, centred on that pixel. Taps
// outside the image read as 0x00 without touching the SRAM.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   start              : one-cycle scan request (accepted only when idle)
//   busy, done         : scan in progress / one-cycle end-of-scan pulse
//   sram_row, sram_col : registered SRAM address
//   sram_write_en      : always 0 (read-only block)
//   sram_din           : always 0
//   sram_sense_en      : registered active-low read strobe (1 = hold)
//   sram_dout          : read data, valid at the edge after the address edge
//   win_valid/win_ready: window handshake
//   win_row, win_col   : window centre coordinates
//   win_pix            : 3x3 window, tap k at [8k+7:8k]
//   dbg_state          : current FSM state
//
// Window handshake: a window transfers on a rising edge where win_valid and
// win_ready are both 1. Once win_valid rises, win_pix/win_row/win_col hold
// until that edge; win_valid never drops without a transfer (except reset).
module img_window_reader
  import img_conv_pkg::*;
#(
  parameter int IMG_ROWS = 256,
  parameter int IMG_COLS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sram_row,
  output logic [7:0]  sram_col,
  output logic        sram_write_en,
  output logic [7:0]  sram_din,
  output logic        sram_sense_en,
  input  logic [7:0]  sram_dout,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [7:0]  win_row,
  output logic [7:0]  win_col,
  output logic [71:0] win_pix,
  output state_t      dbg_state
);

  localparam logic [7:0] LAST_ROW = 8'(IMG_ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(IMG_COLS - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cur_row;
  logic [7:0] cur_col;
  logic [7:0] next_row;
  logic [7:0] next_col;
  logic [3:0] slot;        // issue slots already used in this FETCH
  logic [3:0] slot_count;  // issue slots this FETCH needs (9 or 3)
  logic       full_fetch;
  logic       last_win;

  logic       issue_en;
  logic [3:0] issue_k;
  logic [7:0] issue_row;
  logic [7:0] issue_col;
  logic [7:0] addr_row;
  logic [7:0] addr_col;
  logic       in_bounds;

  // One read in flight: which tap the data returning this cycle belongs to.
  logic       cap_valid;
  logic [3:0] cap_k;
  logic       cap_inb;

  logic [7:0] taps [NUM_TAPS];

  assign sram_write_en = 1'b0;
  assign sram_din      = 8'h00;
  assign win_row       = cur_row;
  assign win_col       = cur_col;
  assign dbg_state     = state;

  assign full_fetch = (cur_col == 8'd0);
  assign slot_count = full_fetch ? 4'd9 : 4'd3;
  assign last_win   = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
  assign next_col   = (cur_col == LAST_COL) ? 8'd0 : cur_col + 8'd1;
  assign next_row   = (cur_col == LAST_COL) ? cur_row + 8'd1 : cur_row;

  always_comb begin
    win_pix = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      win_pix[8*k +: 8] = taps[k];
    end
  end

  img_tap_bounds #(
    .IMG_ROWS (IMG_ROWS),
    .IMG_COLS (IMG_COLS)
  ) u_bounds (
    .tap_idx    (issue_k),
    .centre_row (issue_row),
    .centre_col (issue_col),
    .addr_row   (addr_row),
    .addr_col   (addr_col),
    .in_bounds  (in_bounds)
  );

  // Next state and tap issue. The first tap of a window is issued on the
  // same edge that enters FETCH, so on those transitions the issue uses the
  // centre being loaded rather than the current one.
  always_comb begin
    state_next = state;
    issue_en   = 1'b0;
    issue_k    = 4'd0;
    issue_row  = cur_row;
    issue_col  = cur_col;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          issue_en   = 1'b1;
          issue_row  = 8'd0;
          issue_col  = 8'd0;
        end
      end
      ST_FETCH: begin
        if (slot < slot_count) begin
          issue_en = 1'b1;
          issue_k  = full_fetch ? slot : shift_tap_idx(slot);
        end else begin
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (win_ready) begin
          if (last_win) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FETCH;
            issue_en   = 1'b1;
            issue_row  = next_row;
            issue_col  = next_col;
            issue_k    = (next_col == 8'd0) ? 4'd0 : 4'd2;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      win_valid     <= 1'b0;
      cur_row       <= 8'd0;
      cur_col       <= 8'd0;
      slot          <= 4'd0;
      sram_row      <= 8'd0;
      sram_col      <= 8'd0;
      sram_sense_en <= 1'b1;
      cap_valid     <= 1'b0;
      cap_k         <= 4'd0;
      cap_inb       <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        taps[k] <= 8'h00;
      end
    end else begin
      state <= state_next;
      done  <= 1'b0;

      if (cap_valid) begin
        taps[cap_k] <= cap_inb ? sram_dout : 8'h00;
      end
      cap_valid <= issue_en;
      cap_k     <= issue_k;
      cap_inb   <= in_bounds;

      // Out-of-image taps still burn their slot but leave the SRAM idle and
      // the address untouched.
      if (issue_en) begin
        sram_sense_en <= ~in_bounds;
        if (in_bounds) begin
          sram_row <= addr_row;
          sram_col <= addr_col;
        end
      end else begin
        sram_sense_en <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            cur_row <= 8'd0;
            cur_col <= 8'd0;
            slot    <= 4'd1;
          end
        end
        ST_FETCH: begin
          if (slot < slot_count) begin
            slot <= slot + 4'd1;
          end else begin
            win_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_win) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              cur_row <= next_row;
              cur_col <= next_col;
              slot    <= 4'd1;
              // Sliding right: reuse the two left columns of the old window.
              if (next_col != 8'd0) begin
                taps[0] <= taps[1];
                taps[1] <= taps[2];
                taps[3] <= taps[4];
                taps[4] <= taps[5];
                taps[6] <= taps[7];
                taps[7] <= taps[8];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_window_reader.sv
module tb_img_window_reader;
  import img_conv_pkg::*;

  localparam int AR = 4;
  localparam int AC = 4;

  typedef struct {
    bit          is_b;
    int          r;
    int          c;
    logic [71:0] pix;
  } win_vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A : 4x4 ----------------
  logic        a_start = 1'b0;
  logic        a_ready = 1'b0;
  logic        a_busy, a_done, a_we, a_sense, a_valid;
  logic [7:0]  a_srow, a_scol, a_din, a_dout, a_wrow, a_wcol;
  logic [71:0] a_pix;
  state_t      a_state;
  logic [7:0]  mem_a [65536];

  always_comb begin
    a_dout = 8'hEE;
    if (!a_sense) a_dout = mem_a[{a_srow, a_scol}];
  end

  img_window_reader #(.IMG_ROWS(AR), .IMG_COLS(AC)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .sram_row(a_srow), .sram_col(a_scol), .sram_write_en(a_we), .sram_din(a_din),
    .sram_sense_en(a_sense), .sram_dout(a_dout),
    .win_valid(a_valid), .win_ready(a_ready), .win_row(a_wrow), .win_col(a_wcol),
    .win_pix(a_pix), .dbg_state(a_state)
  );

  // ---------------- instance B : 1x1 ----------------
  logic        b_start = 1'b0;
  logic        b_ready = 1'b0;
  logic        b_busy, b_done, b_we, b_sense, b_valid;
  logic [7:0]  b_srow, b_scol, b_din, b_dout, b_wrow, b_wcol;
  logic [71:0] b_pix;
  state_t      b_state;

  assign b_dout = (!b_sense && b_srow == 8'd0 && b_scol == 8'd0) ? 8'hA5 : 8'hEE;

  img_window_reader #(.IMG_ROWS(1), .IMG_COLS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .sram_row(b_srow), .sram_col(b_scol), .sram_write_en(b_we), .sram_din(b_din),
    .sram_sense_en(b_sense), .sram_dout(b_dout),
    .win_valid(b_valid), .win_ready(b_ready), .win_row(b_wrow), .win_col(b_wcol),
    .win_pix(b_pix), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  logic [87:0] exp_q [$];
  logic [71:0] obs_pix [AR*AC];
  logic [71:0] b_obs;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: window straight from the image definition.
  function automatic logic [71:0] model_pix(input int r, input int c);
    logic [71:0] p;
    int rr;
    int cc;
    p = '0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if (rr >= 0 && rr < AR && cc >= 0 && cc < AC) p[8*k +: 8] = mem_a[16'(rr * 256 + cc)];
    end
    return p;
  endfunction

  // SRAM reads expected while fetching window (r,c): every in-image tap that is fetched.
  function automatic int model_reads(input int r, input int c);
    int n;
    int rr;
    int cc;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
      if ((c == 0 || k % 3 == 2) && rr >= 0 && rr < AR && cc >= 0 && cc < AC) n++;
    end
    return n;
  endfunction

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},  a_busy,  0);
    check({tag, "_done"},  a_done,  0);
    check({tag, "_valid"}, a_valid, 0);
    check({tag, "_pix"},   a_pix,   0);
    check({tag, "_wrc"},   {a_wrow, a_wcol}, 0);
    check({tag, "_sram"},  {a_srow, a_scol}, 0);
    check({tag, "_sense"}, a_sense, 1);
    check({tag, "_state"}, a_state, ST_IDLE);
  endtask

  // Runs one scan on A. Returns early with window stop_at valid and unacknowledged.
  task automatic scan_a(input bit rand_hold, input int stop_at);
    int cnt;
    int lowcnt;
    int hold;
    int r;
    int c;
    logic [71:0] held;
    exp_q.delete();
    for (int rr = 0; rr < AR; rr++)
      for (int cc = 0; cc < AC; cc++)
        exp_q.push_back({8'(rr), 8'(cc), model_pix(rr, cc)});
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    for (int w = 0; w < AR * AC; w++) begin
      r = w / AC;
      c = w % AC;
      cnt = 0;
      lowcnt = 0;
      @(negedge clk);
      if (w == 0) check("busy_after_start", a_busy, 1);
      while (!a_valid && cnt < 40) begin
        if (!a_sense) lowcnt++;
        @(posedge clk); cnt++; @(negedge clk);
      end
      check("window_valid", a_valid, 1);
      if (!a_valid) return;
      check("fetch_cycles", cnt, (c == 0) ? 9 : 3);
      check("sram_reads", lowcnt, model_reads(r, c));
      check("window", {a_wrow, a_wcol, a_pix}, exp_q.pop_front());
      obs_pix[w] = a_pix;
      if (w == stop_at) return;
      hold = rand_hold ? int'($urandom_range(0, 3)) : ((r == 2 && c == 2) ? 5 : 0);
      held = a_pix;
      for (int i = 0; i < hold; i++) begin
        if (rand_hold) a_start = 1'($urandom_range(0, 1));
        @(posedge clk); #1 a_start = 1'b0;
        @(negedge clk);
        check("hold_valid", a_valid, 1);
        check("hold_pix",   a_pix, held);
        check("hold_sense", a_sense, 1);
      end
      a_ready = 1'b1;
      @(posedge clk); #1 a_ready = 1'b0;
    end
    @(negedge clk);
    check("done_pulse",  a_done,  1);
    check("busy_clear",  a_busy,  0);
    check("valid_clear", a_valid, 0);
    @(posedge clk); @(negedge clk);
    check("done_one_cycle", a_done, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_vec_t vecs[6];
    int cnt;
    int lowcnt;

    vecs[0] = '{1'b0, 0, 0, 72'h11_10_00_01_00_00_00_00_00};
    vecs[1] = '{1'b0, 1, 1, 72'h22_21_20_12_11_10_02_01_00};
    vecs[2] = '{1'b0, 2, 2, 72'h33_32_31_23_22_21_13_12_11};
    vecs[3] = '{1'b0, 3, 3, 72'h00_00_00_00_33_32_00_23_22};
    vecs[4] = '{1'b0, 0, 3, 72'h00_13_12_00_03_02_00_00_00};
    vecs[5] = '{1'b1, 0, 0, 72'h00_00_00_00_A5_00_00_00_00};

    for (int i = 0; i < 65536; i++) mem_a[i] = 8'hDD;
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++)
        mem_a[16'(r * 256 + c)] = 8'(16 * r + c);

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a("reset");
    check("reset_we_din", {a_we, a_din}, 0);
    check("reset_b", {b_busy, b_valid, b_sense}, 3'b001);
    @(posedge clk); #1 rst = 1'b0;

    // directed scan of the 16r+c image, 5-cycle stall at (2,2)
    scan_a(1'b0, AR * AC);

    // reset five cycles into the first FETCH
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_a("rst_fetch");
    @(posedge clk); #1 rst = 1'b0;

    // fresh start after that reset, stop holding window (0,0)
    scan_a(1'b0, 0);
    // reset in EMIT, colliding with a handshake and a start request
    a_ready = 1'b1;
    a_start = 1'b1;
    rst     = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    a_start = 1'b0;
    @(negedge clk);
    check_reset_a("rst_emit");
    @(posedge clk); #1 rst = 1'b0;

    // random images, random back-pressure, stray start pulses
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < AR; r++)
        for (int c = 0; c < AC; c++)
          mem_a[16'(r * 256 + c)] = 8'($urandom);
      scan_a(1'b1, AR * AC);
    end
    // restore 16r+c contents for the table comparisons below
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++)
        mem_a[16'(r * 256 + c)] = 8'(16 * r + c);
    scan_a(1'b0, AR * AC);

    // 1x1 image
    b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cnt = 0;
    lowcnt = 0;
    @(negedge clk);
    check("b_busy", b_busy, 1);
    while (!b_valid && cnt < 40) begin
      if (!b_sense) lowcnt++;
      @(posedge clk); cnt++; @(negedge clk);
    end
    check("b_latency", cnt, 9);
    check("b_reads", lowcnt, 1);
    check("b_centre", {b_wrow, b_wcol}, 0);
    b_obs = b_pix;
    b_ready = 1'b1;
    @(posedge clk); #1 b_ready = 1'b0;
    @(negedge clk);
    check("b_done", {b_done, b_busy, b_valid}, 3'b100);
    @(posedge clk); @(negedge clk);
    check("b_done_one_cycle", b_done, 0);

    // table of known windows
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_b) check("table_b", b_obs, vecs[i].pix);
      else check($sformatf("table_%0d_%0d", vecs[i].r, vecs[i].c),
                 obs_pix[vecs[i].r * AC + vecs[i].c], vecs[i].pix);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
